// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared 16:1 single-bit mux.
// Each grantee may hold the output for at most HOLD consecutive cycles.
//
// state | meaning
// IDLE  | no grant active, valid=0, sel holds last grantee
// GRANT | one requester owns the shared output, hold_cnt counts its cycles
module rr_mux_arbiter #(
    parameter int HOLD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] in,
    output logic [3:0]  sel,
    output logic [15:0] grant,
    output logic        valid,
    output logic        out
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t      state, state_nxt;
    logic [3:0]  ptr, ptr_nxt;
    logic [7:0]  hold_cnt, hold_cnt_nxt;
    logic [3:0]  sel_nxt;
    logic [15:0] grant_nxt;
    logic        valid_nxt;

    logic        release_now;
    logic [3:0]  search_base;
    logic [3:0]  search_idx;
    logic [3:0]  winner;
    logic        found;

    assign release_now = (req[sel] == 1'b0) || (hold_cnt == HOLD_LAST);

    // On release the search starts just past the old grantee, so it is seen last.
    assign search_base = (state == GRANT && release_now) ? sel + 4'd1 : ptr;

    always_comb begin
        winner     = '0;
        found      = 1'b0;
        search_idx = '0;
        for (int i = 0; i < 16; i++) begin
            search_idx = search_base + 4'(i);
            if (!found && req[search_idx]) begin
                winner = search_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        sel_nxt      = sel;
        grant_nxt    = grant;
        valid_nxt    = valid;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = GRANT;
                    sel_nxt      = winner;
                    grant_nxt    = 16'd1 << winner;
                    valid_nxt    = 1'b1;
                    hold_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (!release_now) begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end else begin
                    ptr_nxt = sel + 4'd1;
                    if (found) begin
                        sel_nxt      = winner;
                        grant_nxt    = 16'd1 << winner;
                        hold_cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            sel      <= '0;
            grant    <= '0;
            valid    <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            sel      <= sel_nxt;
            grant    <= grant_nxt;
            valid    <= valid_nxt;
        end
    end

    assign out = valid & in[sel];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: three instances (HOLD=4,1,2) on shared stimulus,
// each compared against a queue-free arithmetic reference model every cycle.
module tb_rr_mux_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] din = '0;

    logic [3:0]  sel_o   [3];
    logic [15:0] grant_o [3];
    logic        valid_o [3];
    logic        out_o   [3];

    int n_checks = 0;
    int n_fail   = 0;

    int m_valid [3];
    int m_sel   [3];
    int m_cnt   [3];
    int m_ptr   [3];

    always #5 clk = ~clk;

    rr_mux_arbiter #(.HOLD(4)) u_h4 (
        .clk(clk), .rst_n(rst_n), .req(req), .in(din),
        .sel(sel_o[0]), .grant(grant_o[0]), .valid(valid_o[0]), .out(out_o[0]));
    rr_mux_arbiter #(.HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .req(req), .in(din),
        .sel(sel_o[1]), .grant(grant_o[1]), .valid(valid_o[1]), .out(out_o[1]));
    rr_mux_arbiter #(.HOLD(2)) u_h2 (
        .clk(clk), .rst_n(rst_n), .req(req), .in(din),
        .sel(sel_o[2]), .grant(grant_o[2]), .valid(valid_o[2]), .out(out_o[2]));

    function automatic int hold_of(int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 2;
    endfunction

    function automatic int find_winner(int start, logic [15:0] r);
        for (int i = 0; i < 16; i++) begin
            int j;
            j = (start + i) % 16;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 0; m_sel[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
        end
    endtask

    task automatic model_step(int k, logic [15:0] r);
        int w;
        if (m_valid[k] == 0) begin
            w = find_winner(m_ptr[k], r);
            if (w >= 0) begin
                m_valid[k] = 1; m_sel[k] = w; m_cnt[k] = 0;
            end
        end else if (r[m_sel[k]] && m_cnt[k] < hold_of(k) - 1) begin
            m_cnt[k] = m_cnt[k] + 1;
        end else begin
            m_ptr[k] = (m_sel[k] + 1) % 16;
            w = find_winner(m_ptr[k], r);
            if (w >= 0) begin
                m_sel[k] = w; m_cnt[k] = 0;
            end else begin
                m_valid[k] = 0;
            end
        end
    endtask

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_models();
        for (int k = 0; k < 3; k++) begin
            logic [15:0] eg;
            logic        eo;
            eg = m_valid[k] ? (16'd1 << m_sel[k]) : 16'd0;
            eo = m_valid[k] ? din[m_sel[k]] : 1'b0;
            check($sformatf("valid[h%0d]", hold_of(k)), 16'(valid_o[k]), 16'(m_valid[k]));
            check($sformatf("sel[h%0d]", hold_of(k)), 16'(sel_o[k]), 16'(m_sel[k]));
            check($sformatf("grant[h%0d]", hold_of(k)), grant_o[k], eg);
            check($sformatf("out[h%0d]", hold_of(k)), 16'(out_o[k]), 16'(eo));
        end
    endtask

    task automatic cycle(logic [15:0] r, logic [15:0] d);
        @(negedge clk);
        req = r;
        din = d;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, r);
        #1;
        check_models();
    endtask

    // Reset is asserted between edges and its effect checked before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_valid", 16'(valid_o[k]), 16'd0);
            check("rst_grant", grant_o[k], 16'd0);
            check("rst_out", 16'(out_o[k]), 16'd0);
            check("rst_sel", 16'(sel_o[k]), 16'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Two requesters, HOLD=4: 0 x4, 15 x4, then 0 again.
        for (int c = 0; c < 9; c++) begin
            cycle(16'h8001, 16'($urandom));
            check("r28_sel", 16'(sel_o[0]), (c < 4 || c == 8) ? 16'd0 : 16'd15);
            check("r28_valid", 16'(valid_o[0]), 16'd1);
        end
        cycle(16'h0000, 16'hFFFF);

        // Single-edge request, then drop.
        cycle(16'h0010, 16'hFFFF);
        check("r29_sel", 16'(sel_o[0]), 16'd4);
        check("r29_grant", grant_o[0], 16'h0010);
        cycle(16'h0000, 16'hFFFF);
        check("r29_idle_valid", 16'(valid_o[0]), 16'd0);
        check("r29_idle_sel", 16'(sel_o[0]), 16'd4);
        check("r29_idle_out", 16'(out_o[0]), 16'd0);

        // HOLD=1 sweep with a one-hot data pattern.
        do_reset();
        for (int c = 0; c < 17; c++) begin
            cycle(16'hFFFF, 16'h0020);
            check("r30_sel", 16'(sel_o[1]), 16'(c % 16));
            check("r30_out", 16'(out_o[1]), (c % 16 == 5) ? 16'd1 : 16'd0);
        end

        // Sole requester with HOLD=2 is re-granted with no gap.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            cycle(16'h0200, 16'h0200);
            check("r31_sel", 16'(sel_o[2]), 16'd9);
            check("r31_valid", 16'(valid_o[2]), 16'd1);
        end

        // Mid-grant reset, then regrant of 7 from ptr=0.
        do_reset();
        cycle(16'h0080, 16'h0080);
        check("r32_pre_sel", 16'(sel_o[0]), 16'd7);
        check("r32_pre_out", 16'(out_o[0]), 16'd1);
        do_reset();
        cycle(16'h0080, 16'h0080);
        check("r32_post_sel", 16'(sel_o[0]), 16'd7);
        check("r32_post_valid", 16'(valid_o[0]), 16'd1);

        // Full rotation at HOLD=4 including the 15 -> 0 wrap.
        do_reset();
        for (int c = 0; c < 66; c++) begin
            cycle(16'hFFFF, 16'($urandom));
            check("r33_sel", 16'(sel_o[0]), 16'((c / 4) % 16));
        end

        // Randomized traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [15:0] r;
            case ($urandom_range(0, 3))
                0:       r = 16'($urandom) & 16'($urandom) & 16'($urandom);
                1:       r = 16'($urandom) & 16'($urandom);
                2:       r = 16'($urandom);
                default: r = '0;
            endcase
            if ($urandom_range(0, 60) == 0) do_reset();
            cycle(r, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
